// File: rtl/frac_baud_generator_if.sv
// Divisor configuration channel between the UART register block (master)
// and the fractional baud generator (slave).
interface frac_baud_generator_if #(
  parameter int DIV_INT_WIDTH  = 16,
  parameter int DIV_FRAC_WIDTH = 4
);

  logic                      cfg_valid;
  logic [DIV_INT_WIDTH-1:0]  cfg_div_int;
  logic [DIV_FRAC_WIDTH-1:0] cfg_div_frac;
  logic                      cfg_ready;
  logic                      cfg_error;

  modport master (
    output cfg_valid,
    output cfg_div_int,
    output cfg_div_frac,
    input  cfg_ready,
    input  cfg_error
  );

  modport slave (
    input  cfg_valid,
    input  cfg_div_int,
    input  cfg_div_frac,
    output cfg_ready,
    output cfg_error
  );

endinterface

// File: rtl/frac_baud_generator.sv
// Fractional baud generator: an rx oversampling strobe every div_int or
// div_int+1 cycles (fraction spread by an accumulator) and a tx strobe on
// every OVERSAMPLE-th rx strobe. The divisor is reprogrammed through a
// valid/ready channel and swapped in only at a safe point.
module frac_baud_generator #(
  parameter int DIV_INT_WIDTH    = 16,
  parameter int DIV_FRAC_WIDTH   = 4,
  parameter int OVERSAMPLE       = 16,
  parameter int DEFAULT_DIV_INT  = 27,
  parameter int DEFAULT_DIV_FRAC = 2
) (
  input  logic                 clk_50mhz,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 rx_sync,
  frac_baud_generator_if.slave cfg,
  output logic                 rx_clock_enable,
  output logic                 tx_clock_enable
);

  localparam int IW   = DIV_INT_WIDTH;
  localparam int FW   = DIV_FRAC_WIDTH;
  localparam int OS_W = $clog2(OVERSAMPLE);

  logic [IW-1:0]   div_int_reg, pend_int_reg, cnt_reg;
  logic [FW-1:0]   div_frac_reg, pend_frac_reg, acc_reg;
  logic            long_reg, pend_reg;
  logic [OS_W-1:0] os_cnt_reg;
  logic            rx_stb_reg, tx_stb_reg;
  logic            cfg_ready_reg, cfg_error_reg;

  logic [IW:0]     period_last;
  logic [FW:0]     acc_sum;
  logic            wrap, os_last, tx_edge, apply, accept, cfg_ok;

  // Last count of the current period, one bit wider so a 2^IW-cycle period fits.
  assign period_last = {1'b0, div_int_reg} + {{IW{1'b0}}, long_reg} - {{IW{1'b0}}, 1'b1};
  assign acc_sum     = {1'b0, acc_reg} + {1'b0, div_frac_reg};
  // A resync edge never produces a strobe, so it masks the wrap.
  assign wrap        = enable && !rx_sync && ({1'b0, cnt_reg} == period_last);
  assign os_last     = (os_cnt_reg == OS_W'(OVERSAMPLE - 1));
  assign tx_edge     = wrap && os_last;
  // Swap the divisor only where a phase restart is harmless.
  assign apply       = pend_reg && (tx_edge || !enable || rx_sync);
  assign accept      = cfg.cfg_valid && cfg_ready_reg;
  assign cfg_ok      = (cfg.cfg_div_int >= IW'(2));

  // Period counter, fractional accumulator, oversample counter and divisor swap.
  always_ff @(posedge clk_50mhz or posedge reset) begin
    if (reset) begin
      div_int_reg  <= IW'(DEFAULT_DIV_INT);
      div_frac_reg <= FW'(DEFAULT_DIV_FRAC);
      cnt_reg      <= '0;
      acc_reg      <= '0;
      long_reg     <= 1'b0;
      os_cnt_reg   <= '0;
    end else begin
      if (rx_sync) begin
        cnt_reg    <= '0;
        os_cnt_reg <= '0;
      end else if (enable) begin
        if (wrap) begin
          cnt_reg    <= '0;
          acc_reg    <= acc_sum[FW-1:0];
          long_reg   <= acc_sum[FW];
          os_cnt_reg <= os_last ? '0 : os_cnt_reg + 1'b1;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
      if (apply) begin
        div_int_reg  <= pend_int_reg;
        div_frac_reg <= pend_frac_reg;
        cnt_reg      <= '0;
        acc_reg      <= '0;
        long_reg     <= 1'b0;
        os_cnt_reg   <= '0;
      end
    end
  end

  // Registered strobes; both are zero while held or on a resync edge.
  always_ff @(posedge clk_50mhz or posedge reset) begin
    if (reset) begin
      rx_stb_reg <= 1'b0;
      tx_stb_reg <= 1'b0;
    end else begin
      rx_stb_reg <= wrap;
      tx_stb_reg <= tx_edge;
    end
  end

  // Configuration handshake: latch a legal divisor as pending, flag illegal ones.
  always_ff @(posedge clk_50mhz or posedge reset) begin
    if (reset) begin
      pend_reg      <= 1'b0;
      pend_int_reg  <= '0;
      pend_frac_reg <= '0;
      cfg_ready_reg <= 1'b1;
      cfg_error_reg <= 1'b0;
    end else begin
      cfg_error_reg <= accept && !cfg_ok;
      if (accept && cfg_ok) begin
        pend_reg      <= 1'b1;
        pend_int_reg  <= cfg.cfg_div_int;
        pend_frac_reg <= cfg.cfg_div_frac;
        cfg_ready_reg <= 1'b0;
      end else if (apply) begin
        pend_reg      <= 1'b0;
        cfg_ready_reg <= 1'b1;
      end
    end
  end

  assign rx_clock_enable = rx_stb_reg;
  assign tx_clock_enable = tx_stb_reg;
  assign cfg.cfg_ready   = cfg_ready_reg;
  assign cfg.cfg_error   = cfg_error_reg;

endmodule

// File: tb/tb_frac_baud_generator.sv
// Directed bench for frac_baud_generator: expected strobe edge numbers are
// queued when each stimulus phase starts and compared with the strobe edges
// the monitor records.
module tb_frac_baud_generator;

  logic clk_50mhz = 1'b0;
  logic reset, enable, rx_sync;
  logic rx_clock_enable, tx_clock_enable;

  always #10 clk_50mhz = ~clk_50mhz;

  frac_baud_generator_if #(.DIV_INT_WIDTH(16), .DIV_FRAC_WIDTH(4)) cfg_bus ();

  frac_baud_generator #(
    .DIV_INT_WIDTH(16), .DIV_FRAC_WIDTH(4), .OVERSAMPLE(16),
    .DEFAULT_DIV_INT(27), .DEFAULT_DIV_FRAC(2)
  ) dut (
    .clk_50mhz      (clk_50mhz),
    .reset          (reset),
    .enable         (enable),
    .rx_sync        (rx_sync),
    .cfg            (cfg_bus),
    .rx_clock_enable(rx_clock_enable),
    .tx_clock_enable(tx_clock_enable)
  );

  int checks   = 0;
  int failures = 0;
  int edge_num = 0;
  int rx_q[$], tx_q[$], exp_rx[$], exp_tx[$];

  // Rising edges since reset release; edge k is the k-th edge with reset low.
  always @(posedge clk_50mhz) begin
    if (reset) edge_num <= 0;
    else       edge_num <= edge_num + 1;
  end

  // Record the edge after which each strobe is high; tx must ride on an rx strobe.
  always @(negedge clk_50mhz) begin
    if (rx_clock_enable === 1'b1) rx_q.push_back(edge_num);
    if (tx_clock_enable === 1'b1) begin
      tx_q.push_back(edge_num);
      checks++;
      assert (rx_clock_enable === 1'b1) else begin
        failures++;
        $error("FAIL tx_coincident observed=%b expected=1", rx_clock_enable);
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Edge at which rx period j ends: j*d plus the number of long periods before it.
  function automatic int ends(input int j, input int d, input int fr);
    return j * d + ((j - 1) * fr) / 16;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic wait_until_edge(input int n);
    while (edge_num < n) @(negedge clk_50mhz);
  endtask

  task automatic compare_rx(input string tag);
    int e, a;
    while (exp_rx.size() > 0) begin
      e = exp_rx.pop_front();
      if (rx_q.size() == 0) begin
        check_val({tag, "_rx_missing"}, 32'hFFFF_FFFF, e);
      end else begin
        a = rx_q.pop_front();
        $display("%s rx strobe edge=%0d expected=%0d", tag, a, e);
        check_val({tag, "_rx"}, a, e);
      end
    end
    check_val({tag, "_rx_extra"}, rx_q.size(), 0);
    rx_q.delete();
  endtask

  task automatic compare_tx(input string tag);
    int e, a;
    while (exp_tx.size() > 0) begin
      e = exp_tx.pop_front();
      if (tx_q.size() == 0) begin
        check_val({tag, "_tx_missing"}, 32'hFFFF_FFFF, e);
      end else begin
        a = tx_q.pop_front();
        $display("%s tx strobe edge=%0d expected=%0d", tag, a, e);
        check_val({tag, "_tx"}, a, e);
      end
    end
    check_val({tag, "_tx_extra"}, tx_q.size(), 0);
    tx_q.delete();
  endtask

  initial begin
    int s_edge, e34, e66, n_long;
    reset   = 1'b1;
    enable  = 1'b1;
    rx_sync = 1'b0;
    cfg_bus.cfg_valid    = 1'b0;
    cfg_bus.cfg_div_int  = '0;
    cfg_bus.cfg_div_frac = '0;

    // Reset state
    repeat (3) @(negedge clk_50mhz);
    check_val("reset_rx", rx_clock_enable, 0);
    check_val("reset_tx", tx_clock_enable, 0);
    check_val("reset_err", cfg_bus.cfg_error, 0);
    check_val("reset_ready", cfg_bus.cfg_ready, 1);
    reset = 1'b0;

    // Default divisor 27 + 2/16, with a rejected divisor early in period 1
    for (int j = 1; j <= 32; j++) exp_rx.push_back(ends(j, 27, 2));
    exp_tx.push_back(ends(16, 27, 2));
    exp_tx.push_back(ends(32, 27, 2));
    wait_until_edge(3);
    cfg_bus.cfg_valid    = 1'b1;
    cfg_bus.cfg_div_int  = 16'd1;
    cfg_bus.cfg_div_frac = 4'd5;
    @(negedge clk_50mhz);
    cfg_bus.cfg_valid = 1'b0;
    check_val("bad_cfg_err", cfg_bus.cfg_error, 1);
    check_val("bad_cfg_ready", cfg_bus.cfg_ready, 1);
    @(negedge clk_50mhz);
    check_val("bad_cfg_err_clear", cfg_bus.cfg_error, 0);
    wait_until_edge(ends(32, 27, 2) + 1);
    if (tx_q.size() >= 2) check_val("tx_spacing", tx_q[1] - tx_q[0], 434);
    else                  check_val("tx_count", tx_q.size(), 2);
    n_long = 0;
    if (rx_q.size() >= 32) begin
      for (int i = 16; i < 32; i++) if (rx_q[i] - rx_q[i-1] == 28) n_long++;
    end
    check_val("long_periods_per_16", n_long, 2);
    compare_rx("default");
    compare_tx("default");

    // Hold for 100 cycles in the middle of period 33
    wait_until_edge(877);
    enable = 1'b0;
    repeat (100) @(negedge clk_50mhz);
    check_val("hold_quiet", rx_q.size() + tx_q.size(), 0);
    enable = 1'b1;
    exp_rx.push_back(ends(33, 27, 2) + 100);
    exp_rx.push_back(ends(34, 27, 2) + 100);
    e34 = ends(34, 27, 2) + 100;
    wait_until_edge(e34 + 1);
    compare_rx("hold");
    compare_tx("hold");

    // Resync on the edge that sees cnt = 10 of period 35
    s_edge = e34 + 11;
    wait_until_edge(s_edge - 1);
    rx_sync = 1'b1;
    @(negedge clk_50mhz);
    rx_sync = 1'b0;
    for (int j = 35; j <= 50; j++) exp_rx.push_back(s_edge + ends(j, 27, 2) - ends(34, 27, 2));
    exp_tx.push_back(s_edge + ends(50, 27, 2) - ends(34, 27, 2));
    wait_until_edge(s_edge + ends(50, 27, 2) - ends(34, 27, 2) + 1);
    compare_rx("sync");
    compare_tx("sync");

    // New divisor 4.0 mid-bit; applied on the next tx strobe
    e66 = s_edge + ends(66, 27, 2) - ends(34, 27, 2);
    wait_until_edge(s_edge + ends(50, 27, 2) - ends(34, 27, 2) + 30);
    cfg_bus.cfg_valid    = 1'b1;
    cfg_bus.cfg_div_int  = 16'd4;
    cfg_bus.cfg_div_frac = 4'd0;
    @(negedge clk_50mhz);
    check_val("cfg_accept_ready", cfg_bus.cfg_ready, 0);
    check_val("cfg_accept_err", cfg_bus.cfg_error, 0);
    cfg_bus.cfg_div_int = 16'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_50mhz);
      check_val("ignored_cfg_err", cfg_bus.cfg_error, 0);
      check_val("ignored_cfg_ready", cfg_bus.cfg_ready, 0);
    end
    cfg_bus.cfg_valid = 1'b0;
    for (int j = 51; j <= 66; j++) exp_rx.push_back(s_edge + ends(j, 27, 2) - ends(34, 27, 2));
    for (int k = 1; k <= 20; k++) exp_rx.push_back(e66 + 4 * k);
    exp_tx.push_back(e66);
    exp_tx.push_back(e66 + 64);
    wait_until_edge(e66 - 1);
    check_val("ready_before_apply", cfg_bus.cfg_ready, 0);
    @(negedge clk_50mhz);
    check_val("ready_after_apply", cfg_bus.cfg_ready, 1);
    wait_until_edge(e66 + 81);
    compare_rx("div4");
    compare_tx("div4");

    // Asynchronous reset with a divisor pending, while an rx strobe is high
    cfg_bus.cfg_valid    = 1'b1;
    cfg_bus.cfg_div_int  = 16'd8;
    cfg_bus.cfg_div_frac = 4'd3;
    @(negedge clk_50mhz);
    cfg_bus.cfg_valid = 1'b0;
    check_val("pend_ready", cfg_bus.cfg_ready, 0);
    wait_until_edge(e66 + 84);
    check_val("pre_reset_rx", rx_clock_enable, 1);
    #2 reset = 1'b1;
    #1;
    check_val("async_reset_rx", rx_clock_enable, 0);
    check_val("async_reset_tx", tx_clock_enable, 0);
    check_val("async_reset_err", cfg_bus.cfg_error, 0);
    check_val("async_reset_ready", cfg_bus.cfg_ready, 1);
    repeat (3) @(negedge clk_50mhz);
    reset = 1'b0;
    rx_q.delete();
    tx_q.delete();
    for (int j = 1; j <= 3; j++) exp_rx.push_back(ends(j, 27, 2));
    wait_until_edge(82);
    check_val("post_reset_ready", cfg_bus.cfg_ready, 1);
    compare_rx("post_reset");
    compare_tx("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
